// File: rtl/mem_writer_packer.sv
// Frames a {addr,len} write request plus packed payload into a writer request, AXI-Stream beats and a status reply.
// REQ one cycle after accept, beats pass through at full rate under tready; optional `MEM_WRITER_PACKER_STATS_EN adds stat_xfer_cnt.
module mem_writer_packer #(
   parameter logic [3:0] TID   = 4'h0,
   parameter logic [3:0] TDEST = 4'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] req_data,
   input  logic        req_vld,
   output logic        req_rdy,
   input  logic [31:0] in_data,
   input  logic        in_vld,
   output logic        in_rdy,
   output logic        resp_data,
   output logic        resp_vld,
   input  logic        resp_rdy,
   output logic [31:0] write_req_data,
   output logic        write_req_vld,
   input  logic        write_req_rdy,
   output logic [31:0] axi_st_tdata,
   output logic [3:0]  axi_st_tstr,
   output logic [3:0]  axi_st_tkeep,
   output logic        axi_st_tlast,
   output logic [3:0]  axi_st_tid,
   output logic [3:0]  axi_st_tdest,
   output logic        axi_st_tvalid,
   input  logic        axi_st_tready,
   input  logic        write_resp_data,
   input  logic        write_resp_vld,
   output logic        write_resp_rdy
`ifdef MEM_WRITER_PACKER_STATS_EN
   ,
   output logic [15:0] stat_xfer_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, REQ, DATA, WAIT, RESP} state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] len;
   } req_t;

   state_t      state;
   state_t      state_nxt;
   req_t        req_in;
   req_t        req_q;
   logic [15:0] beat_cnt;
   logic [15:0] beats_init;
   logic        status_q;
   logic        last_beat;
   logic [3:0]  last_keep;

   assign req_in    = req_t'(req_data);
   assign last_beat = (beat_cnt == 16'd1);

   // ceil(len/4) without a 17-bit adder: whole words plus one for any partial tail
   assign beats_init = {2'b00, req_in.len[15:2]} + {15'd0, |req_in.len[1:0]};

   always_comb begin
      last_keep = 4'hF;
      case (req_q.len[1:0])
         2'd1:    last_keep = 4'h1;
         2'd2:    last_keep = 4'h3;
         2'd3:    last_keep = 4'h7;
         default: last_keep = 4'hF;
      endcase
   end

   assign axi_st_tid   = TID;
   assign axi_st_tdest = TDEST;

   // Every output is forced quiet while rst is high, even though the state register only clears at the edge
   always_comb begin
      state_nxt      = state;
      req_rdy        = 1'b0;
      in_rdy         = 1'b0;
      resp_data      = 1'b0;
      resp_vld       = 1'b0;
      write_req_data = '0;
      write_req_vld  = 1'b0;
      axi_st_tdata   = '0;
      axi_st_tstr    = 4'h0;
      axi_st_tkeep   = 4'h0;
      axi_st_tlast   = 1'b0;
      axi_st_tvalid  = 1'b0;
      write_resp_rdy = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               req_rdy = 1'b1;
               if (req_vld) begin
                  state_nxt = (req_in.len == 16'd0) ? RESP : REQ;
               end
            end
            REQ: begin
               write_req_vld  = 1'b1;
               write_req_data = req_q;
               if (write_req_rdy) begin
                  state_nxt = DATA;
               end
            end
            DATA: begin
               axi_st_tvalid = in_vld;
               in_rdy        = axi_st_tready;
               axi_st_tdata  = in_data;
               axi_st_tlast  = last_beat;
               axi_st_tkeep  = last_beat ? last_keep : 4'hF;
               axi_st_tstr   = last_beat ? last_keep : 4'hF;
               if (in_vld && axi_st_tready && last_beat) begin
                  state_nxt = WAIT;
               end
            end
            WAIT: begin
               write_resp_rdy = 1'b1;
               if (write_resp_vld) begin
                  state_nxt = RESP;
               end
            end
            RESP: begin
               resp_vld  = 1'b1;
               resp_data = status_q;
               if (resp_rdy) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req_q    <= '0;
         beat_cnt <= '0;
         status_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req_vld) begin
            req_q    <= req_in;
            beat_cnt <= beats_init;
            status_q <= 1'b0;
         end
         if (state == DATA && in_vld && axi_st_tready) begin
            beat_cnt <= beat_cnt - 16'd1;
         end
         if (state == WAIT && write_resp_vld) begin
            status_q <= write_resp_data;
         end
      end
   end

`ifdef MEM_WRITER_PACKER_STATS_EN
   logic [15:0] xfer_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt_q <= '0;
      end else if (state == RESP && resp_rdy) begin
         xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
   end

   assign stat_xfer_cnt = rst ? 16'd0 : xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mem_writer_packer.sv
// Directed bench for mem_writer_packer: vector table of whole transfers plus hand-written stall/reset sequences.
module tb_mem_writer_packer;

   localparam logic [3:0] P_TID   = 4'h5;
   localparam logic [3:0] P_TDEST = 4'hA;

   logic        clk;
   logic        rst;
   logic [31:0] req_data;
   logic        req_vld;
   logic        req_rdy;
   logic [31:0] in_data;
   logic        in_vld;
   logic        in_rdy;
   logic        resp_data;
   logic        resp_vld;
   logic        resp_rdy;
   logic [31:0] write_req_data;
   logic        write_req_vld;
   logic        write_req_rdy;
   logic [31:0] axi_st_tdata;
   logic [3:0]  axi_st_tstr;
   logic [3:0]  axi_st_tkeep;
   logic        axi_st_tlast;
   logic [3:0]  axi_st_tid;
   logic [3:0]  axi_st_tdest;
   logic        axi_st_tvalid;
   logic        axi_st_tready;
   logic        write_resp_data;
   logic        write_resp_vld;
   logic        write_resp_rdy;
`ifdef MEM_WRITER_PACKER_STATS_EN
   logic [15:0] stat_xfer_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_writer_packer #(.TID(P_TID), .TDEST(P_TDEST)) dut (
      .clk(clk), .rst(rst),
      .req_data(req_data), .req_vld(req_vld), .req_rdy(req_rdy),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .resp_data(resp_data), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
      .write_req_data(write_req_data), .write_req_vld(write_req_vld), .write_req_rdy(write_req_rdy),
      .axi_st_tdata(axi_st_tdata), .axi_st_tstr(axi_st_tstr), .axi_st_tkeep(axi_st_tkeep),
      .axi_st_tlast(axi_st_tlast), .axi_st_tid(axi_st_tid), .axi_st_tdest(axi_st_tdest),
      .axi_st_tvalid(axi_st_tvalid), .axi_st_tready(axi_st_tready),
      .write_resp_data(write_resp_data), .write_resp_vld(write_resp_vld), .write_resp_rdy(write_resp_rdy)
`ifdef MEM_WRITER_PACKER_STATS_EN
      , .stat_xfer_cnt(stat_xfer_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] req;
      logic        wr_status;
      int          beats;
      logic [3:0]  last_keep;
      logic        exp_resp;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1 with the DUT idle
   task automatic run_xfer(input logic [31:0] rq, input logic wr, input int nb,
                           input logic [3:0] lk, input logic exp_rsp);
      logic [31:0] bd;
      req_data = rq;
      req_vld  = 1'b1;
      @(negedge clk);
      chk("idle_req_rdy", 32'(req_rdy), 32'd1);
      tick();
      req_vld  = 1'b0;
      req_data = '0;
      if (nb == 0) begin
         resp_rdy = 1'b1;
         @(negedge clk);
         chk("zl_no_wreq", 32'(write_req_vld), 32'd0);
         chk("zl_no_tvalid", 32'(axi_st_tvalid), 32'd0);
         chk("zl_resp_vld", 32'(resp_vld), 32'd1);
         chk("zl_resp_data", 32'(resp_data), 32'd0);
      end else begin
         @(negedge clk);
         chk("wreq_vld", 32'(write_req_vld), 32'd1);
         chk("wreq_data", write_req_data, rq);
         chk("req_in_rdy_lo", 32'(in_rdy), 32'd0);
         tick();
         for (int b = 0; b < nb; b++) begin
            bd            = {rq[23:16], 8'(b), 16'hC0DE};
            in_data       = bd;
            in_vld        = 1'b1;
            axi_st_tready = 1'b1;
            @(negedge clk);
            chk("beat_tvalid", 32'(axi_st_tvalid), 32'd1);
            chk("beat_in_rdy", 32'(in_rdy), 32'd1);
            chk("beat_tdata", axi_st_tdata, bd);
            chk("beat_tkeep", 32'(axi_st_tkeep), (b == nb - 1) ? 32'(lk) : 32'hF);
            chk("beat_tstr", 32'(axi_st_tstr), (b == nb - 1) ? 32'(lk) : 32'hF);
            chk("beat_tlast", 32'(axi_st_tlast), (b == nb - 1) ? 32'd1 : 32'd0);
            tick();
         end
         in_vld          = 1'b0;
         in_data         = '0;
         write_resp_vld  = 1'b1;
         write_resp_data = wr;
         @(negedge clk);
         chk("wait_wresp_rdy", 32'(write_resp_rdy), 32'd1);
         chk("wait_tvalid_lo", 32'(axi_st_tvalid), 32'd0);
         tick();
         write_resp_vld  = 1'b0;
         write_resp_data = 1'b0;
         resp_rdy        = 1'b1;
         @(negedge clk);
         chk("resp_vld", 32'(resp_vld), 32'd1);
         chk("resp_data", 32'(resp_data), 32'(exp_rsp));
      end
      tick();
      resp_rdy = 1'b0;
      @(negedge clk);
      chk("b2b_resp_vld_lo", 32'(resp_vld), 32'd0);
      chk("b2b_req_rdy", 32'(req_rdy), 32'd1);
      tick();
   endtask

   initial begin
      int          beat;
      logic [3:0]  ek;
      logic [31:0] bd;

      vecs[0] = '{32'h0100_0008, 1'b0, 2, 4'hF, 1'b0};
      vecs[1] = '{32'h0020_0005, 1'b0, 2, 4'h1, 1'b0};
      vecs[2] = '{32'h0040_0000, 1'b0, 0, 4'hF, 1'b0};
      vecs[3] = '{32'h0030_0007, 1'b0, 2, 4'h7, 1'b0};
      vecs[4] = '{32'h0050_0006, 1'b0, 2, 4'h3, 1'b0};
      vecs[5] = '{32'h0060_0001, 1'b0, 1, 4'h1, 1'b0};
      vecs[6] = '{32'h0070_0004, 1'b1, 1, 4'hF, 1'b1};

      rst = 1'b1; req_data = '0; req_vld = 1'b0; in_data = '0; in_vld = 1'b0;
      resp_rdy = 1'b0; write_req_rdy = 1'b1; axi_st_tready = 1'b1;
      write_resp_data = 1'b0; write_resp_vld = 1'b0;

      repeat (3) tick();
      @(negedge clk);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_tid", 32'(axi_st_tid), 32'(P_TID));
      chk("rst_tdest", 32'(axi_st_tdest), 32'(P_TDEST));
      chk("rst_resp_vld", 32'(resp_vld), 32'd0);
      chk("rst_wreq_vld", 32'(write_req_vld), 32'd0);
`ifdef MEM_WRITER_PACKER_STATS_EN
      chk("rst_stat", 32'(stat_xfer_cnt), 32'd0);
`endif
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_rdy", 32'(req_rdy), 32'd1);
      tick();

      for (int i = 0; i < 7; i++) begin
         run_xfer(vecs[i].req, vecs[i].wr_status, vecs[i].beats, vecs[i].last_keep, vecs[i].exp_resp);
      end

      // Length 13 with a stalled writer request, then tready toggling every cycle
      write_req_rdy = 1'b0;
      req_data = 32'h0080_000D;
      req_vld  = 1'b1;
      tick();
      req_vld  = 1'b0;
      req_data = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("a_wreq_hold_vld", 32'(write_req_vld), 32'd1);
         chk("a_wreq_hold_data", write_req_data, 32'h0080_000D);
         tick();
      end
      write_req_rdy = 1'b1;
      tick();
      beat   = 0;
      in_vld = 1'b1;
      for (int c = 0; c < 20 && beat < 4; c++) begin
         axi_st_tready = ((c % 2) == 1);
         bd            = {8'hA5, 8'(beat), 16'h1234};
         in_data       = bd;
         ek            = (beat == 3) ? 4'h1 : 4'hF;
         @(negedge clk);
         chk("a_in_rdy_mirror", 32'(in_rdy), 32'(axi_st_tready));
         chk("a_tdata", axi_st_tdata, bd);
         chk("a_tkeep", 32'(axi_st_tkeep), 32'(ek));
         chk("a_tlast", 32'(axi_st_tlast), (beat == 3) ? 32'd1 : 32'd0);
         tick();
         if (axi_st_tready) beat++;
      end
      chk("a_beat_count", 32'(beat), 32'd4);
      in_vld = 1'b0; axi_st_tready = 1'b1;
      write_resp_vld = 1'b1;
      @(negedge clk);
      chk("a_wresp_rdy", 32'(write_resp_rdy), 32'd1);
      tick();
      write_resp_vld = 1'b0;
      resp_rdy = 1'b1;
      @(negedge clk);
      chk("a_resp_vld", 32'(resp_vld), 32'd1);
      tick();
      resp_rdy = 1'b0;

      // Writer error with the requester stalling; a second request must be held off
      req_data = 32'h00A0_0004;
      req_vld  = 1'b1;
      tick();
      req_vld = 1'b0;
      tick();
      in_vld = 1'b1; in_data = 32'h1111_2222;
      @(negedge clk);
      chk("b_tlast", 32'(axi_st_tlast), 32'd1);
      chk("b_tkeep", 32'(axi_st_tkeep), 32'hF);
      tick();
      in_vld = 1'b0;
      write_resp_vld = 1'b1; write_resp_data = 1'b1;
      tick();
      write_resp_vld = 1'b0; write_resp_data = 1'b0;
      req_data = 32'h00B0_0000; req_vld = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("b_hold_resp_vld", 32'(resp_vld), 32'd1);
         chk("b_hold_resp_data", 32'(resp_data), 32'd1);
         chk("b_hold_req_rdy", 32'(req_rdy), 32'd0);
         tick();
      end
      req_vld = 1'b0; req_data = '0;
      resp_rdy = 1'b1;
      @(negedge clk);
      chk("b_resp_vld", 32'(resp_vld), 32'd1);
      tick();
      resp_rdy = 1'b0;
      @(negedge clk);
      chk("b_idle_req_rdy", 32'(req_rdy), 32'd1);
      chk("b_no_second_wreq", 32'(write_req_vld), 32'd0);
      chk("b_no_second_resp", 32'(resp_vld), 32'd0);
`ifdef MEM_WRITER_PACKER_STATS_EN
      chk("stat_before_rst", 32'(stat_xfer_cnt), 32'd9);
`endif
      tick();

      // Reset after one of three beats
      req_data = 32'h00C0_000C; req_vld = 1'b1;
      tick();
      req_vld = 1'b0; req_data = '0;
      tick();
      in_vld = 1'b1; in_data = 32'h3333_4444;
      @(negedge clk);
      chk("c_first_beat_vld", 32'(axi_st_tvalid), 32'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("c_rst_tvalid", 32'(axi_st_tvalid), 32'd0);
      chk("c_rst_in_rdy", 32'(in_rdy), 32'd0);
      chk("c_rst_tdata", axi_st_tdata, 32'd0);
      chk("c_rst_tkeep", 32'(axi_st_tkeep), 32'd0);
      chk("c_rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("c_rst_tid", 32'(axi_st_tid), 32'(P_TID));
      tick();
      rst = 1'b0; in_vld = 1'b0; in_data = '0;
      @(negedge clk);
      chk("c_idle_req_rdy", 32'(req_rdy), 32'd1);
      chk("c_idle_tvalid", 32'(axi_st_tvalid), 32'd0);
      chk("c_no_resp", 32'(resp_vld), 32'd0);
`ifdef MEM_WRITER_PACKER_STATS_EN
      chk("c_stat_cleared", 32'(stat_xfer_cnt), 32'd0);
`endif
      tick();
      run_xfer(32'h00D0_0004, 1'b0, 1, 4'hF, 1'b0);
`ifdef MEM_WRITER_PACKER_STATS_EN
      chk("c_stat_one", 32'(stat_xfer_cnt), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
